// File: rtl/uart_dev.sv
// uart_dev -- bus-side responder for the on-chip UART.
//
// Decodes word accesses on the UART slot of the peripheral bus, buffers
// transmit and receive bytes in two FIFOs, and drives the byte-level
// send/receive handshake of the `uart` serial core. Raises a registered
// level interrupt.
//
// Optional feature: define UART_DEV_LOOPBACK_EN to implement CTRL bit3
// (internal loopback of TX FIFO bytes into the RX FIFO).
//
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   addr_i[31:0]       bus address, only [3:2] decoded
//   data_i[31:0]       bus write data
//   data_o[31:0]       bus read data (registered, holds outside ACK)
//   sel_i[1:0]         access size, ignored
//   rd_i, we_i         read / write request, held until ack
//   ack_o              one-cycle completion pulse
//   tx_data_o[7:0]     byte to uart data_in
//   tx_send_o          one-cycle send strobe to uart
//   tx_sent_i          one-cycle pulse from uart when byte is out
//   rx_data_i[7:0]     byte from uart
//   rx_received_i      one-cycle pulse from uart, byte valid
//   interrupt          level interrupt, registered
//
// Register map (addr_i[3:2]):
//   0 DATA   wr: push TX FIFO (drop if full); rd: pop RX FIFO (0 if empty)
//   1 STATUS bit0 rx_nonempty, bit1 tx_full, bit2 rx_overrun, bit3 tx_empty,
//            [16+:9] rx count
//   2 CTRL   bit0 rx_int_en, bit1 tx_int_en, bit2 W1 clears rx_overrun,
//            bit3 loopback (only with UART_DEV_LOOPBACK_EN)
//   3 reserved
//
// Handshake: a request (rd_i or we_i, we_i wins if both) is taken in
// BUS_IDLE; its side effect happens in that cycle, ack_o pulses for exactly
// the next cycle with data_o valid, and the FSM then waits in BUS_WAIT until
// both rd_i and we_i are low before accepting another request.

module uart_dev #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [1:0]  sel_i,
  input  logic        rd_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_send_o,
  input  logic        tx_sent_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_received_i,
  output logic        interrupt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_WAIT} bus_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  bus_state_t bus_state;
  tx_state_t  tx_state;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count, rx_count;

  logic rx_int_en, tx_int_en, rx_overrun, loop_en;

  // Bits of the bus that carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{sel_i, addr_i[31:4], addr_i[1:0], data_i[31:8]};

  // Request decode: only meaningful in BUS_IDLE.
  logic [1:0] reg_sel;
  logic       accept, data_wr, data_rd, ctrl_wr;
  assign reg_sel = addr_i[3:2];
  assign accept  = (bus_state == BUS_IDLE) && (rd_i || we_i);
  assign data_wr = accept && we_i  && (reg_sel == REG_DATA);
  assign data_rd = accept && !we_i && (reg_sel == REG_DATA);
  assign ctrl_wr = accept && we_i  && (reg_sel == REG_CTRL);

  logic tx_full, tx_empty, rx_full, rx_nonempty;
  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_nonempty = (rx_count != '0);

  logic       tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic [7:0] rx_push_byte;
  assign tx_push = data_wr && !tx_full;
  assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;
  // In loopback the TX head goes straight into the RX FIFO and the serial
  // core's receive strobe is ignored.
  assign rx_push_req  = loop_en ? tx_pop : rx_received_i;
  assign rx_push_byte = loop_en ? tx_mem[tx_rd_ptr] : rx_data_i;
  assign rx_push      = rx_push_req && !rx_full;
  assign rx_pop       = data_rd && rx_nonempty;

`ifdef UART_DEV_LOOPBACK_EN
  logic ctrl_loop;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ctrl_loop <= 1'b0;
    else if (ctrl_wr) ctrl_loop <= data_i[3];
  end
  assign loop_en = ctrl_loop;
`else
  assign loop_en = 1'b0;
`endif

  // Read mux, evaluated in the accept cycle.
  logic [31:0] rd_value;
  always_comb begin
    rd_value = '0;
    case (reg_sel)
      REG_DATA:   if (rx_nonempty) rd_value[7:0] = rx_mem[rx_rd_ptr];
      REG_STATUS: begin
        rd_value[0]       = rx_nonempty;
        rd_value[1]       = tx_full;
        rd_value[2]       = rx_overrun;
        rd_value[3]       = tx_empty;
        rd_value[16 +: CW] = rx_count;
      end
      REG_CTRL: begin
        rd_value[0] = rx_int_en;
        rd_value[1] = tx_int_en;
        rd_value[3] = loop_en;
      end
      default: rd_value = '0;
    endcase
  end

  // Bus FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_state <= BUS_IDLE;
      ack_o     <= 1'b0;
      data_o    <= '0;
    end else begin
      ack_o <= 1'b0;
      case (bus_state)
        BUS_IDLE: if (accept) begin
          bus_state <= BUS_ACK;
          ack_o     <= 1'b1;
          data_o    <= we_i ? 32'h0 : rd_value;
        end
        BUS_ACK:  bus_state <= BUS_WAIT;
        BUS_WAIT: if (!rd_i && !we_i) bus_state <= BUS_IDLE;
        default:  bus_state <= BUS_IDLE;
      endcase
    end
  end

  // Control bits; a new overrun in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_int_en  <= 1'b0;
      tx_int_en  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_int_en <= data_i[0];
        tx_int_en <= data_i[1];
      end
      if (rx_push_req && rx_full) rx_overrun <= 1'b1;
      else if (ctrl_wr && data_i[2]) rx_overrun <= 1'b0;
    end
  end

  // FIFO storage (no reset needed, guarded by counts).
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= data_i[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // TX FSM. In loopback the pop above already moved the byte; stay idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state  <= TX_IDLE;
      tx_data_o <= 8'h00;
      tx_send_o <= 1'b0;
    end else begin
      tx_send_o <= 1'b0;
      case (tx_state)
        TX_IDLE: if (tx_pop && !loop_en) begin
          tx_data_o <= tx_mem[tx_rd_ptr];
          tx_send_o <= 1'b1;
          tx_state  <= TX_BUSY;
        end
        TX_BUSY: if (tx_sent_i) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) interrupt <= 1'b0;
    else interrupt <= (rx_int_en && (rx_nonempty || rx_overrun)) ||
                      (tx_int_en && tx_empty && (tx_state == TX_IDLE));
  end

endmodule

// File: tb/tb_uart_dev.sv
module tb_uart_dev;

  localparam int DEPTH = 16;

  logic        clk, rstn;
  logic [31:0] addr_i, data_i, data_o;
  logic [1:0]  sel_i;
  logic        rd_i, we_i, ack_o;
  logic [7:0]  tx_data_o;
  logic        tx_send_o, tx_sent_i;
  logic [7:0]  rx_data_i;
  logic        rx_received_i, interrupt;

  int checks = 0;
  int errors = 0;

  // Scoreboard: bytes expected on the serial-core send interface.
  logic [7:0] exp_q[$];
  // Reference model of the receive side.
  logic [7:0] model_rx_q[$];
  bit         model_ovr = 1'b0;

  int send_cnt   = 0;
  bit tx_auto    = 1'b0;
  int manual_req = 0;
  int manual_done = 0;

`ifdef UART_DEV_LOOPBACK_EN
  localparam logic [31:0] CTRL_F_READ = 32'h0000_000B;
`else
  localparam logic [31:0] CTRL_F_READ = 32'h0000_0003;
`endif

  uart_dev #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o),
    .tx_data_o(tx_data_o), .tx_send_o(tx_send_o), .tx_sent_i(tx_sent_i),
    .rx_data_i(rx_data_i), .rx_received_i(rx_received_i), .interrupt(interrupt)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Send monitor + serial-core responder
  initial begin
    logic [7:0] e;
    tx_sent_i = 1'b0;
    forever begin
      @(negedge clk);
      tx_sent_i = 1'b0;
      if (rstn && tx_send_o) begin
        send_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_send: unexpected byte 0x%02h, no byte expected", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          if (tx_data_o !== e) begin
            errors++;
            $display("FAIL tx_send data: got 0x%02h expected 0x%02h", tx_data_o, e);
          end
        end
        if (tx_auto) tx_sent_i = 1'b1;
      end
      if (manual_req != manual_done) begin
        tx_sent_i = 1'b1;
        manual_done++;
      end
    end
  end

  // Driver tasks
  task automatic bus_op(input bit wr, input logic [1:0] rg, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    logic [31:0] a;
    @(negedge clk);
    a      = $urandom();
    a[3:2] = rg;
    addr_i = a;
    data_i = wd;
    sel_i  = 2'($urandom_range(0, 3));
    we_i   = wr;
    rd_i   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    lat    = -1;
    rd     = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        lat = i;
        rd  = data_o;
        break;
      end
    end
    @(negedge clk);
    rd_i = 1'b0;
    we_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic bus_check(input bit wr, input logic [1:0] rg, input logic [31:0] wd,
                           input logic [31:0] exp, input string name);
    logic [31:0] rd;
    int lat;
    bus_op(wr, rg, wd, rd, lat);
    check({name, " ack latency"}, lat, 1);
    check(name, rd, exp);
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    rx_data_i     = b;
    rx_received_i = 1'b1;
    @(negedge clk);
    rx_received_i = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  rg;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd, exp_stat;
    logic [7:0]  b;
    int lat, n, op, sc0;

    vecs[0]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0008};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 2'd2, 32'h3,        32'h0};
    vecs[3]  = '{1'b0, 2'd2, 32'h0,        32'h3};
    vecs[4]  = '{1'b1, 2'd2, 32'h7,        32'h0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,        32'h3};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 2'd2, 32'hF,        32'h0};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,        CTRL_F_READ};
    vecs[10] = '{1'b1, 2'd2, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h0};

    // Reset
    rstn = 1'b0; addr_i = '0; data_i = '0; sel_i = '0; rd_i = 1'b0; we_i = 1'b0;
    rx_data_i = '0; rx_received_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack_o", ack_o, 0);
    check("reset data_o", data_o, 0);
    check("reset tx_data_o", tx_data_o, 0);
    check("reset tx_send_o", tx_send_o, 0);
    check("reset interrupt", interrupt, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);

    // Register vectors
    for (int i = 0; i < 12; i++) begin
      bus_check(vecs[i].wr, vecs[i].rg, vecs[i].wd, vecs[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d data_o hold", i), data_o, vecs[i].exp);
    end

    // TX: send timing, second byte waits for tx_sent_i
    exp_q.push_back(8'h41);
    @(negedge clk);
    addr_i = 32'h0; data_i = 32'h41; we_i = 1'b1;
    @(posedge clk); #1;
    check("tx write ack", ack_o, 1);
    check("tx send not early", tx_send_o, 0);
    @(negedge clk);
    we_i = 1'b0;
    @(posedge clk); #1;
    check("tx send at N+2", tx_send_o, 1);
    check("tx data 0x41", tx_data_o, 32'h41);
    @(posedge clk);
    @(posedge clk); #1;
    exp_q.push_back(8'h42);
    bus_check(1'b1, 2'd0, 32'h42, 32'h0, "write 0x42");
    repeat (10) @(posedge clk);
    #1;
    check("no send while busy", send_cnt, 1);
    manual_req++;
    n = 0;
    while (send_cnt < 2 && n < 20) begin @(posedge clk); n++; end
    check("send after tx_sent", send_cnt, 2);
    exp_q.push_back(8'h43);
    bus_check(1'b1, 2'd0, 32'h43, 32'h0, "write 0x43");

    // RX overflow with one byte waiting in the TX FIFO
    for (int i = 0; i <= DEPTH; i++) rx_inject(8'(i));
    bus_check(1'b0, 2'd1, 32'h0, 32'h0010_0005, "status rx full overrun");
    for (int i = 0; i < DEPTH; i++) bus_check(1'b0, 2'd0, 32'h0, i, $sformatf("rx read %0d", i));
    bus_check(1'b0, 2'd0, 32'h0, 32'h0, "rx read empty");
    bus_check(1'b0, 2'd1, 32'h0, 32'h0000_0004, "status overrun sticky");
    bus_check(1'b1, 2'd2, 32'h4, 32'h0, "ctrl clear overrun");
    bus_check(1'b0, 2'd1, 32'h0, 32'h0, "status after clear");
    manual_req++;
    n = 0;
    while (send_cnt < 3 && n < 20) begin @(posedge clk); n++; end
    check("third send", send_cnt, 3);
    manual_req++;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard empty after tx test", exp_q.size(), 0);
    tx_auto = 1'b1;

    // Interrupts
    bus_check(1'b1, 2'd2, 32'h1, 32'h0, "ctrl rx_int_en");
    check("irq low rx empty", interrupt, 0);
    rx_inject(8'h77);
    repeat (2) @(posedge clk);
    #1;
    check("irq rx byte", interrupt, 1);
    @(negedge clk);
    addr_i = 32'h0; rd_i = 1'b1;
    @(posedge clk); #1;
    check("irq read ack", ack_o, 1);
    check("irq read data", data_o, 32'h77);
    check("irq still high at ack", interrupt, 1);
    @(negedge clk);
    rd_i = 1'b0;
    @(posedge clk); #1;
    check("irq low after pop", interrupt, 0);
    @(posedge clk);
    @(posedge clk); #1;
    bus_check(1'b1, 2'd2, 32'h2, 32'h0, "ctrl tx_int_en");
    check("irq tx empty", interrupt, 1);
    bus_check(1'b1, 2'd2, 32'h0, 32'h0, "ctrl off");
    check("irq off", interrupt, 0);

    // Held read: one ack, one pop
    rx_inject(8'hA1);
    rx_inject(8'hA2);
    @(negedge clk);
    addr_i = 32'h0; rd_i = 1'b1;
    n = 0; rd = '0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        n++;
        if (n == 1) rd = data_o;
      end
    end
    check("held read ack count", n, 1);
    check("held read data", rd, 32'hA1);
    @(negedge clk);
    rd_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus_check(1'b0, 2'd1, 32'h0, 32'h0001_0009, "status after held read");
    bus_check(1'b0, 2'd0, 32'h0, 32'hA2, "read after held read");

`ifdef UART_DEV_LOOPBACK_EN
    sc0 = send_cnt;
    bus_check(1'b1, 2'd2, 32'h8, 32'h0, "ctrl loopback");
    bus_check(1'b1, 2'd0, 32'h5A, 32'h0, "write loop byte");
    repeat (3) @(posedge clk);
    #1;
    check("loopback no send", send_cnt, sc0);
    bus_check(1'b0, 2'd0, 32'h0, 32'h5A, "loopback read");
    bus_check(1'b1, 2'd2, 32'h0, 32'h0, "ctrl loopback off");
`else
    sc0 = 0;
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          b = 8'($urandom());
          rx_inject(b);
          if (model_rx_q.size() < DEPTH) model_rx_q.push_back(b);
          else model_ovr = 1'b1;
        end
        1: begin
          b = 8'($urandom());
          exp_q.push_back(b);
          bus_op(1'b1, 2'd0, {24'($urandom()), b}, rd, lat);
          check("rand write ack", lat, 1);
        end
        2: begin
          bus_op(1'b0, 2'd0, 32'h0, rd, lat);
          check("rand read ack", lat, 1);
          if (model_rx_q.size() != 0) check("rand data read", rd, {24'h0, model_rx_q.pop_front()});
          else check("rand data read empty", rd, 32'h0);
        end
        3: begin
          bus_op(1'b0, 2'd1, 32'h0, rd, lat);
          check("rand status ack", lat, 1);
          exp_stat = {7'h0, 9'(model_rx_q.size()), 13'h0, model_ovr, 1'b0, model_rx_q.size() != 0};
          check("rand status", rd & 32'h01FF_0005, exp_stat);
        end
        default: begin
          bus_op(1'b1, 2'd2, 32'h4, rd, lat);
          check("rand ctrl ack", lat, 1);
          model_ovr = 1'b0;
        end
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("tx scoreboard drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
